// File: rtl/da_pkg.sv
// Shared types and sizing helpers for the distributed-arithmetic convolution block.
package da_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam int LUT_W = 8;

  function automatic int acc_w(input int data_w);
    return data_w + LUT_W;
  endfunction
endpackage

// File: rtl/lut_mul.sv
// Bit-plane weight sum: adds WEIGHT_k for every tap whose plane bit is set.
// Built as a 4-tap and a 3-tap constant table whose outputs are summed.
module lut_mul
  import da_pkg::*;
#(
  parameter int               KERNEL_H = 7,
  parameter logic signed [4:0] WEIGHT_0 = 5'sd1,
  parameter logic signed [4:0] WEIGHT_1 = -5'sd2,
  parameter logic signed [4:0] WEIGHT_2 = 5'sd3,
  parameter logic signed [4:0] WEIGHT_3 = -5'sd4,
  parameter logic signed [4:0] WEIGHT_4 = 5'sd5,
  parameter logic signed [4:0] WEIGHT_5 = -5'sd6,
  parameter logic signed [4:0] WEIGHT_6 = 5'sd7
) (
  input  logic [KERNEL_H-1:0]      d,
  output logic signed [LUT_W-1:0] sum
);

  function automatic logic signed [LUT_W-1:0] lut_lo(input logic [3:0] b);
    logic signed [LUT_W-1:0] s;
    s = '0;
    if (b[0]) s = s + LUT_W'(WEIGHT_0);
    if (b[1]) s = s + LUT_W'(WEIGHT_1);
    if (b[2]) s = s + LUT_W'(WEIGHT_2);
    if (b[3]) s = s + LUT_W'(WEIGHT_3);
    return s;
  endfunction

  function automatic logic signed [LUT_W-1:0] lut_hi(input logic [2:0] b);
    logic signed [LUT_W-1:0] s;
    s = '0;
    if (b[0]) s = s + LUT_W'(WEIGHT_4);
    if (b[1]) s = s + LUT_W'(WEIGHT_5);
    if (b[2]) s = s + LUT_W'(WEIGHT_6);
    return s;
  endfunction

  always_comb begin
    sum = lut_lo(d[3:0]) + lut_hi(d[6:4]);
  end

endmodule

// File: rtl/da_conv_seq.sv
// Bit-serial 7-tap dot product: one sample bit-plane per cycle, MSB (sign) plane first,
// accumulated with shift-and-add into an exact-width accumulator.
module da_conv_seq
  import da_pkg::*;
#(
  parameter int               DATA_W   = 8,
  parameter int               KERNEL_H = 7,
  parameter logic signed [4:0] WEIGHT_0 = 5'sd1,
  parameter logic signed [4:0] WEIGHT_1 = -5'sd2,
  parameter logic signed [4:0] WEIGHT_2 = 5'sd3,
  parameter logic signed [4:0] WEIGHT_3 = -5'sd4,
  parameter logic signed [4:0] WEIGHT_4 = 5'sd5,
  parameter logic signed [4:0] WEIGHT_5 = -5'sd6,
  parameter logic signed [4:0] WEIGHT_6 = 5'sd7
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [KERNEL_H*DATA_W-1:0]   in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_W+7:0]     out_data,
  output logic                         busy
);

  localparam int ACC_W = acc_w(DATA_W);
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] MSB_IDX = CNT_W'(DATA_W - 1);

  state_t                        state, state_next;
  logic [CNT_W-1:0]              cnt;
  logic signed [ACC_W-1:0]       acc;
  logic [KERNEL_H*DATA_W-1:0]    samples;
  logic [KERNEL_H-1:0]           plane;
  logic signed [LUT_W-1:0]       lut_sum;
  logic signed [ACC_W-1:0]       p;
  logic                          accept;

  always_comb begin
    plane = '0;
    for (int k = 0; k < KERNEL_H; k++) begin
      plane[k] = samples[k*DATA_W + int'(cnt)];
    end
  end

  lut_mul #(
    .KERNEL_H (KERNEL_H),
    .WEIGHT_0 (WEIGHT_0),
    .WEIGHT_1 (WEIGHT_1),
    .WEIGHT_2 (WEIGHT_2),
    .WEIGHT_3 (WEIGHT_3),
    .WEIGHT_4 (WEIGHT_4),
    .WEIGHT_5 (WEIGHT_5),
    .WEIGHT_6 (WEIGHT_6)
  ) u_lut_mul (
    .d   (plane),
    .sum (lut_sum)
  );

  assign p = ACC_W'(lut_sum);

  always_comb begin
    state_next = state;
    in_ready   = (state == IDLE) && rst_n;
    out_valid  = (state == DONE);
    busy       = (state == RUN) || (state == DONE);
    out_data   = '0;
    accept     = in_valid && in_ready;
    case (state)
      IDLE: if (accept) state_next = RUN;
      RUN:  if (cnt == '0) state_next = DONE;
      DONE: begin
        out_data = acc;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      cnt     <= '0;
      samples <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (accept) begin
            samples <= in_data;
            acc     <= '0;
            cnt     <= MSB_IDX;
          end
        end
        RUN: begin
          // The sign plane carries weight -2^(DATA_W-1), so it enters negated.
          if (cnt == MSB_IDX) acc <= -p;
          else                acc <= (acc <<< 1) + p;
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_da_conv_seq.sv
// Directed and randomized bench for da_conv_seq against a plain dot-product model.
module tb_da_conv_seq;
  localparam int DATA_W = 8;
  localparam int K      = 7;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     in_valid;
  logic                     in_ready;
  logic [K*DATA_W-1:0]      in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W+7:0] out_data;
  logic                     busy;

  int errors = 0;
  int checks = 0;
  int wts [K] = '{1, -2, 3, -4, 5, -6, 7};

  da_conv_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic int model(input logic [K*DATA_W-1:0] v);
    int s;
    logic signed [DATA_W-1:0] x;
    s = 0;
    for (int k = 0; k < K; k++) begin
      x = v[k*DATA_W +: DATA_W];
      s += wts[k] * int'(x);
    end
    return s;
  endfunction

  function automatic logic [K*DATA_W-1:0] rand_vec();
    logic [K*DATA_W-1:0] v;
    v[31:0]  = $urandom;
    v[55:32] = 24'($urandom);
    return v;
  endfunction

  function automatic logic [K*DATA_W-1:0] fill(input logic [DATA_W-1:0] x);
    logic [K*DATA_W-1:0] v;
    for (int k = 0; k < K; k++) v[k*DATA_W +: DATA_W] = x;
    return v;
  endfunction

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one vector, returns after the accepting edge with in_valid dropped.
  task automatic send(input logic [K*DATA_W-1:0] v);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check("send_ready", in_ready, 1);
    in_valid = 1'b1;
    in_data  = v;
    tick();
    in_valid = 1'b0;
    in_data  = rand_vec();
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_one(input string tag, input logic [K*DATA_W-1:0] v,
                         input int exp);
    int lat;
    send(v);
    wait_out(lat);
    check({tag, "_lat"}, lat, DATA_W);
    check(tag, out_data, exp);
    tick();
  endtask

  initial begin
    int lat, hs_last, cyc, got, sent, saw, exp_v;
    logic acc_hs, out_hs;
    logic [K*DATA_W-1:0] v;
    int q[$];

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    tick(); tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_data", out_data, 0);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    run_one("all_ones", fill(8'd1), 4);
    run_one("all_min", fill(8'h80), -512);
    v = '0; v[7:0] = 8'd127;
    run_one("x0_max", v, 127);
    v = '0; v[5*DATA_W +: DATA_W] = 8'h80;
    run_one("x5_min", v, 768);
    for (int i = 0; i < 4; i++) begin
      v = rand_vec();
      run_one("rand_directed", v, model(v));
    end

    // Backpressure in DONE with a competing vector offered.
    out_ready = 1'b0;
    v = rand_vec();
    exp_v = model(v);
    send(v);
    wait_out(lat);
    check("bp_lat", lat, DATA_W);
    in_valid = 1'b1;
    in_data  = rand_vec();
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_data", out_data, exp_v);
      check("bp_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_release_valid", out_valid, 0);
    check("bp_release_ready", in_ready, 1);
    check("bp_release_data", out_data, 0);

    // Reset pulse in the third RUN cycle abandons the operation.
    send(rand_vec());
    tick(); tick();
    rst_n = 1'b0;
    tick();
    check("midrun_rst_valid", out_valid, 0);
    rst_n = 1'b1;
    #1;
    check("midrun_rst_ready", in_ready, 1);
    saw = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) saw = 1;
      tick();
    end
    check("midrun_no_valid", saw, 0);
    run_one("after_rst_ones", fill(8'd1), 4);

    // Back-to-back stream, out_ready held high.
    q = {}; got = 0; sent = 0; cyc = 0; hs_last = -1;
    in_valid = 1'b1; in_data = rand_vec(); out_ready = 1'b1;
    while (got < 1000 && cyc < 12000) begin
      acc_hs = in_valid && in_ready;
      out_hs = out_valid && out_ready;
      if (out_hs) begin
        if (q.size() > 0) check("stream_data", out_data, q.pop_front());
        else check("stream_spurious", 1, 0);
        if (hs_last >= 0) check("stream_period", cyc - hs_last, DATA_W + 2);
        hs_last = cyc;
        got++;
      end
      if (acc_hs) begin
        q.push_back(model(in_data));
        sent++;
      end
      tick();
      cyc++;
      if (acc_hs) in_data = rand_vec();
      in_valid = (sent < 1000);
    end
    check("stream_count", got, 1000);
    check("stream_queue_empty", q.size(), 0);

    // Random in_valid gaps and out_ready backpressure.
    q = {}; got = 0; sent = 0; cyc = 0;
    in_valid = 1'b0;
    while (got < 300 && cyc < 20000) begin
      acc_hs = in_valid && in_ready;
      out_hs = out_valid && out_ready;
      if (!out_valid) check("rand_zero_idle", out_data, 0);
      if (out_hs) begin
        if (q.size() > 0) check("rand_data", out_data, q.pop_front());
        else check("rand_spurious", 1, 0);
        got++;
      end
      if (acc_hs) begin
        q.push_back(model(in_data));
        sent++;
      end
      tick();
      cyc++;
      in_valid  = (sent < 300) && ($urandom_range(0, 2) != 0);
      in_data   = rand_vec();
      out_ready = ($urandom_range(0, 1) != 0);
    end
    check("rand_count", got, 300);
    check("rand_queue_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/da_conv_seq.md
DA_CONV_SEQ -- requirements
Module: da_conv_seq

Interface
REQ-001 Parameter DATA_W, default 8: sample width in bits, two's complement; SHALL be 2..16.
REQ-002 Parameter KERNEL_H, default 7: taps; SHALL be fixed at 7, matching the lut_mul LUT split.
REQ-003 Parameters WEIGHT_0..WEIGHT_6, signed 5-bit, defaults 1,-2,3,-4,5,-6,7: tap weights, passed unchanged to lut_mul.
REQ-004 Ports: one clock; reset is synchronous and active-low.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  synchronous active-low reset.
REQ-007 in_valid  input  1  sample vector offered.
REQ-008 in_ready  output  1  block can accept a vector.
REQ-009 in_data  input  KERNEL_H*DATA_W  sample k in bits [k*DATA_W +: DATA_W].
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer takes result.
REQ-012 out_data  output  DATA_W+8  signed result, sum over k of WEIGHT_k*x_k.
REQ-013 busy  output  1  high in RUN or DONE.

Function
REQ-014 FSM states IDLE, RUN, DONE; in_ready SHALL equal (state==IDLE && rst_n).
REQ-015 IDLE: on in_valid&&in_ready, capture all KERNEL_H samples into internal registers, clear accumulator, set bit counter to DATA_W-1, enter RUN.
REQ-016 RUN: each cycle drive lut_mul d[k] = bit[counter] of sample k (MSB plane first); p = sign-extended lut_mul sum (8 bits).
REQ-017 First RUN cycle (counter==DATA_W-1): acc <= -p (sign-plane weight is negative).
REQ-018 Subsequent RUN cycles: acc <= (acc <<< 1) + p; counter decrements each cycle.
REQ-019 After the counter==0 cycle, enter DONE; RUN lasts exactly DATA_W cycles.
REQ-020 DONE: out_valid=1, out_data=acc; both SHALL be held stable until out_valid&&out_ready, then enter IDLE.
REQ-021 Latency: out_valid SHALL rise exactly DATA_W clock edges after the accepting edge.
REQ-022 Throughput: one result per DATA_W+2 cycles with out_ready held high; no accept in RUN or DONE.
REQ-023 in_valid while in_ready=0 SHALL be ignored; in_data changes after acceptance SHALL NOT affect the result.
REQ-024 Accumulator width DATA_W+8 SHALL be exact: no saturation or overflow for any input (|result| <= 2^(DATA_W-1)*112).
REQ-025 out_data SHALL read 0 whenever out_valid=0.

Reset
REQ-026 While rst_n=0 at a clock edge: state IDLE, acc 0, counter 0, sample registers 0, out_valid 0, busy 0, in_ready 0.
REQ-027 Reset asserted mid-RUN or in DONE SHALL abandon the operation with no out_valid pulse; in_ready SHALL be 1 in the first cycle after rst_n returns high.

Structure
REQ-028 Shared package da_pkg SHALL hold the state enum (IDLE/RUN/DONE), LUT_W=8, and ACC_W = DATA_W+8 helper.
REQ-029 Exactly one sub-module instance: lut_mul (DATA_W=8, KERNEL_H=7, weights forwarded); all sequencing lives in da_conv_seq.

Verification
REQ-030 All samples = 1, default weights -> out_data = 4, out_valid 8 edges after accept.
REQ-031 All samples = -128 -> out_data = -512; x0=127, others 0 -> 127; x5=-128, others 0 -> 768.
REQ-032 out_ready low 5 cycles in DONE, in_valid held high -> out_data stable, in_ready 0, no second accept.
REQ-033 rst_n low one cycle on 3rd RUN cycle -> no out_valid; next vector (all 1) -> 4.
REQ-034 1000 back-to-back random vectors, out_ready always 1 -> match behavioural model, result every 10 cycles.
REQ-035 Random out_ready backpressure with random in_valid gaps -> no lost or duplicated results; order preserved.
